// File: rtl/execute_stage_pkg.sv
// Shared constants for the execute stage: ALU opcodes, flag positions and widths.
package execute_stage_pkg;

  localparam int DATA_W = 16;
  localparam int FLAG_W = 4;

  // ALUControl opcode encodings
  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_SHL   = 4'b0100;
  localparam logic [3:0] OP_SHR   = 4'b0101;
  localparam logic [3:0] OP_NOT   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_INC   = 4'b1000;
  localparam logic [3:0] OP_DEC   = 4'b1001;
  localparam logic [3:0] OP_PASSA = 4'b1010;

  // Bit positions inside the {V,C,N,Z} flag vector
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  // Signed overflow of x + y given the sum: operands agree in sign, result does not.
  function automatic logic add_overflow(input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] s);
    add_overflow = (x[15] == y[15]) && (s[15] != x[15]);
  endfunction

  // Signed overflow of x - y given the difference: operands differ in sign and
  // the result sign differs from the minuend.
  function automatic logic sub_overflow(input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] d);
    sub_overflow = (x[15] != y[15]) && (d[15] != x[15]);
  endfunction

endpackage

// File: rtl/execute_stage_alu_core.sv
// Combinational ALU: computes the result and next {V,C,N,Z} flags from the
// operands and the current condition codes (which supply every held flag).
module alu_core
  import execute_stage_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [3:0]  shamt,
  input  logic [3:0]  ccr_in,
  output logic [15:0] result,
  output logic [3:0]  flags
);

  logic [16:0] wide_s;
  logic [15:0] result_s;
  logic [3:0]  flags_s;
  logic        update_zn_s;

  // Opcode decode; flags default to the current ccr so untouched bits are held.
  always_comb begin
    wide_s      = 17'd0;
    result_s    = a;
    flags_s     = ccr_in;
    update_zn_s = 1'b1;
    case (op)
      OP_ADD: begin
        wide_s          = {1'b0, a} + {1'b0, b};
        result_s        = wide_s[15:0];
        flags_s[FLAG_C] = wide_s[16];
        flags_s[FLAG_V] = add_overflow(a, b, wide_s[15:0]);
      end
      OP_SUB: begin
        // B - A; bit 16 of the 17-bit difference is the borrow (B < A).
        wide_s          = {1'b0, b} - {1'b0, a};
        result_s        = wide_s[15:0];
        flags_s[FLAG_C] = wide_s[16];
        flags_s[FLAG_V] = sub_overflow(b, a, wide_s[15:0]);
      end
      OP_AND: begin
        result_s = a & b;
      end
      OP_OR: begin
        result_s = a | b;
      end
      OP_SHL: begin
        // Bit 16 of the widened shift is the last bit shifted out, A[16-n].
        wide_s   = {1'b0, a} << shamt;
        result_s = wide_s[15:0];
        if (shamt != 4'd0) begin
          flags_s[FLAG_C] = wide_s[16];
        end else begin
          flags_s[FLAG_C] = ccr_in[FLAG_C];
        end
      end
      OP_SHR: begin
        // Extra low guard bit catches the last bit shifted out, A[n-1].
        wide_s   = {a, 1'b0} >> shamt;
        result_s = wide_s[16:1];
        if (shamt != 4'd0) begin
          flags_s[FLAG_C] = wide_s[0];
        end else begin
          flags_s[FLAG_C] = ccr_in[FLAG_C];
        end
      end
      OP_NOT: begin
        result_s = ~a;
      end
      OP_PASSB: begin
        result_s    = b;
        update_zn_s = 1'b0;
      end
      OP_INC: begin
        result_s        = a + 16'd1;
        flags_s[FLAG_C] = (a == 16'hFFFF);
        flags_s[FLAG_V] = (a == 16'h7FFF);
      end
      OP_DEC: begin
        result_s        = a - 16'd1;
        flags_s[FLAG_C] = (a == 16'h0000);
        flags_s[FLAG_V] = (a == 16'h8000);
      end
      OP_PASSA: begin
        result_s    = a;
        update_zn_s = 1'b0;
      end
      default: begin
        result_s    = a;
        update_zn_s = 1'b0;
      end
    endcase

    if (update_zn_s) begin
      flags_s[FLAG_Z] = (result_s == 16'h0000);
      flags_s[FLAG_N] = result_s[15];
    end else begin
      flags_s[FLAG_Z] = ccr_in[FLAG_Z];
      flags_s[FLAG_N] = ccr_in[FLAG_N];
    end
  end

  assign result = result_s;
  assign flags  = flags_s;

endmodule

// File: rtl/execute_stage.sv
// Execute stage: selects operand B, runs the ALU and holds the condition-code
// register, which loads the ALU's next flags every cycle.
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        immOrReg,
  input  logic [3:0]  ALUControl,
  input  logic [15:0] RegSrc,
  input  logic [15:0] RegDst,
  input  logic [15:0] immediate,
  output logic [3:0]  newStatus,
  output logic [15:0] ALUResult,
  output logic [3:0]  ccr
);

  logic [15:0] operand_b_s;
  logic [3:0]  ccr_r;
  logic [3:0]  flags_s;
  logic [15:0] result_s;

  // Operand B source: register value or immediate.
  always_comb begin
    if (immOrReg) begin
      operand_b_s = RegDst;
    end else begin
      operand_b_s = immediate;
    end
  end

  alu_core u_alu_core (
    .op     (ALUControl),
    .a      (RegSrc),
    .b      (operand_b_s),
    .shamt  (immediate[3:0]),
    .ccr_in (ccr_r),
    .result (result_s),
    .flags  (flags_s)
  );

  // Condition-code register: cleared on reset, otherwise captures the next flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      ccr_r <= 4'b0000;
    end else begin
      ccr_r <= flags_s;
    end
  end

  assign ALUResult = result_s;
  assign newStatus = flags_s;
  assign ccr       = ccr_r;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed vectors with literal
// expectations plus an arithmetic reference model compared every cycle.
module tb_execute_stage;

  logic        clk;
  logic        rst;
  logic        immOrReg;
  logic [3:0]  ALUControl;
  logic [15:0] RegSrc;
  logic [15:0] RegDst;
  logic [15:0] immediate;
  logic [3:0]  newStatus;
  logic [15:0] ALUResult;
  logic [3:0]  ccr;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;
  logic [3:0] model_ccr;

  execute_stage dut (
    .clk        (clk),
    .rst        (rst),
    .immOrReg   (immOrReg),
    .ALUControl (ALUControl),
    .RegSrc     (RegSrc),
    .RegDst     (RegDst),
    .immediate  (immediate),
    .newStatus  (newStatus),
    .ALUResult  (ALUResult),
    .ccr        (ccr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model from plain integer arithmetic: returns {flags, result}.
  function automatic logic [19:0] model(input logic [3:0] op, input logic sel,
                                        input logic [15:0] a, input logic [15:0] rd,
                                        input logic [15:0] imm, input logic [3:0] cc);
    int ua, ub, sa, sb, wide, n, sr;
    logic [15:0] r;
    logic [3:0]  f;
    bit zn;
    ua = int'(a);
    ub = sel ? int'(rd) : int'(imm);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    n  = int'(imm[3:0]);
    f  = cc;
    zn = 1'b1;
    case (op)
      4'd0: begin
        wide = ua + ub; r = 16'(wide % 65536);
        f[2] = (wide > 65535);
        sr = sa + sb; f[3] = (sr > 32767) || (sr < -32768);
      end
      4'd1: begin
        r = 16'((ub + 65536 - ua) % 65536);
        f[2] = (ub < ua);
        sr = sb - sa; f[3] = (sr > 32767) || (sr < -32768);
      end
      4'd2: r = 16'(ua) & 16'(ub);
      4'd3: r = 16'(ua) | 16'(ub);
      4'd4: begin
        r = 16'((ua * (1 << n)) % 65536);
        if (n != 0) f[2] = ((ua >> (16 - n)) % 2) == 1;
      end
      4'd5: begin
        r = 16'(ua / (1 << n));
        if (n != 0) f[2] = ((ua >> (n - 1)) % 2) == 1;
      end
      4'd6: r = 16'(65535 - ua);
      4'd7: begin r = 16'(ub); zn = 1'b0; end
      4'd8: begin
        r = 16'((ua + 1) % 65536);
        f[2] = (ua == 65535); f[3] = (ua == 32767);
      end
      4'd9: begin
        r = 16'((ua + 65535) % 65536);
        f[2] = (ua == 0); f[3] = (ua == 32768);
      end
      default: begin r = 16'(ua); zn = 1'b0; end
    endcase
    if (zn) begin
      f[0] = (r == 16'd0);
      f[1] = (int'(r) >= 32768);
    end
    return {f, r};
  endfunction

  // Model condition-code register.
  always @(posedge clk) begin
    if (rst) model_ccr <= 4'b0000;
    else begin
      logic [19:0] m;
      m = model(ALUControl, immOrReg, RegSrc, RegDst, immediate, model_ccr);
      model_ccr <= m[19:16];
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      logic [19:0] m;
      m = model(ALUControl, immOrReg, RegSrc, RegDst, immediate, model_ccr);
      n_checks = n_checks + 3;
      if (ALUResult !== m[15:0]) begin
        n_fail = n_fail + 1;
        $display("FAIL model_result op=%b got=%h want=%h", ALUControl, ALUResult, m[15:0]);
      end
      if (newStatus !== m[19:16]) begin
        n_fail = n_fail + 1;
        $display("FAIL model_flags op=%b got=%b want=%b", ALUControl, newStatus, m[19:16]);
      end
      if (ccr !== model_ccr) begin
        n_fail = n_fail + 1;
        $display("FAIL model_ccr got=%b want=%b", ccr, model_ccr);
      end
    end
  end

  // Drive one vector after a rising edge and check literal expectations.
  task automatic vec(input string name, input logic [3:0] op, input logic sel,
                     input logic [15:0] a, input logic [15:0] rd, input logic [15:0] imm,
                     input logic [15:0] exp_res, input logic [3:0] exp_fl,
                     input logic [3:0] mask);
    @(posedge clk);
    #1;
    ALUControl = op; immOrReg = sel; RegSrc = a; RegDst = rd; immediate = imm;
    #1;
    n_checks = n_checks + 1;
    if (ALUResult !== exp_res) begin
      n_fail = n_fail + 1;
      $display("FAIL %s_result got=%h want=%h", name, ALUResult, exp_res);
    end
    if (mask != 4'b0000) begin
      n_checks = n_checks + 1;
      if (((newStatus ^ exp_fl) & mask) != 4'b0000) begin
        n_fail = n_fail + 1;
        $display("FAIL %s_flags got=%b want=%b mask=%b", name, newStatus, exp_fl, mask);
      end
    end
  endtask

  task automatic check_bits(input string name, input logic [3:0] got, input logic [3:0] want);
    n_checks = n_checks + 1;
    if (got !== want) begin
      n_fail = n_fail + 1;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  initial begin
    rst = 1'b1; immOrReg = 1'b0; ALUControl = 4'b1010;
    RegSrc = 16'h0000; RegDst = 16'h0000; immediate = 16'h0000;
    @(posedge clk); @(posedge clk); #1;
    check_bits("reset_ccr", ccr, 4'b0000);
    check_bits("reset_held_flags", newStatus, 4'b0000);
    rst = 1'b0;
    checking = 1'b1;

    //   name      op       sel   A         RegDst    imm       result    flags    mask
    vec("add1",   4'b0000, 1'b1, 16'h0005, 16'h0006, 16'h0000, 16'h000B, 4'b0000, 4'b1111);
    vec("add2",   4'b0000, 1'b1, 16'h800F, 16'h800F, 16'h0000, 16'h001E, 4'b1100, 4'b1111);
    vec("addimm", 4'b0000, 1'b0, 16'h0001, 16'h0064, 16'h0002, 16'h0003, 4'b0000, 4'b1111);
    vec("sub1",   4'b0001, 1'b1, 16'h0002, 16'h0005, 16'h0000, 16'h0003, 4'b0000, 4'b1111);
    vec("sub2",   4'b0001, 1'b1, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 4'b0001, 4'b1111);
    vec("sub3",   4'b0001, 1'b1, 16'h0005, 16'h0002, 16'h0000, 16'hFFFD, 4'b0110, 4'b1111);
    vec("shl1",   4'b0100, 1'b0, 16'h000F, 16'h0000, 16'h0002, 16'h003C, 4'b0000, 4'b0111);
    vec("shl2",   4'b0100, 1'b0, 16'hC00F, 16'h0000, 16'h0002, 16'h003C, 4'b0100, 4'b0111);
    vec("shl0",   4'b0100, 1'b0, 16'h8000, 16'h0000, 16'hFFF0, 16'h8000, 4'b0010, 4'b0011);
    vec("shr1",   4'b0101, 1'b0, 16'h01E0, 16'h0000, 16'h0002, 16'h0078, 4'b0000, 4'b0111);
    vec("shr2",   4'b0101, 1'b0, 16'h000F, 16'h0000, 16'h0002, 16'h0003, 4'b0100, 4'b0111);
    vec("and",    4'b0010, 1'b1, 16'h0005, 16'h0005, 16'h0000, 16'h0005, 4'b0000, 4'b0011);
    vec("or",     4'b0011, 1'b1, 16'h00F0, 16'h000F, 16'h0000, 16'h00FF, 4'b0000, 4'b0011);
    vec("not",    4'b0110, 1'b0, 16'h000F, 16'h0000, 16'h0000, 16'hFFF0, 4'b0010, 4'b0011);
    vec("passa",  4'b1010, 1'b1, 16'h0000, 16'h000F, 16'h0000, 16'h0000, 4'b0000, 4'b0000);
    vec("passb",  4'b0111, 1'b1, 16'h0000, 16'h000F, 16'h0000, 16'h000F, 4'b0000, 4'b0000);
    vec("inc1",   4'b1000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 4'b0000, 4'b1111);
    vec("dec1",   4'b1001, 1'b0, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 4'b0001, 4'b1111);
    vec("incmax", 4'b1000, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 4'b0101, 4'b1111);
    vec("incv",   4'b1000, 1'b0, 16'h7FFF, 16'h0000, 16'h0000, 16'h8000, 4'b1010, 4'b1111);
    vec("decv",   4'b1001, 1'b0, 16'h8000, 16'h0000, 16'h0000, 16'h7FFF, 4'b1000, 4'b1111);
    vec("dec0",   4'b1001, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 4'b0110, 4'b1111);
    vec("op1111", 4'b1111, 1'b1, 16'h1234, 16'h5678, 16'h0000, 16'h1234, 4'b0000, 4'b0000);

    // Carry set by ADD, then held through PASS A from the register.
    vec("regadd", 4'b0000, 1'b1, 16'h800F, 16'h800F, 16'h0000, 16'h001E, 4'b1100, 4'b1111);
    vec("reghold",4'b1010, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b1100, 4'b1100);
    check_bits("ccr_loaded", ccr, 4'b1100);

    // Reset for one edge clears the register and the held flags.
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_bits("ccr_after_rst", ccr, 4'b0000);
    check_bits("held_c_after_rst", {3'b000, newStatus[2]}, 4'b0000);
    rst = 1'b0;
    vec("post_rst", 4'b1000, 1'b0, 16'h0010, 16'h0000, 16'h0000, 16'h0011, 4'b0000, 4'b1111);

    @(posedge clk); #1;
    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
